// File: rtl/float_8bit_unpack_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : float_8bit_unpack_if                                            |
// | Purpose  : valid/ready bus carrying mantissa/exponent in and integer out   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface float_8bit_unpack_if #(
  parameter int W  = 8,
  parameter int PW = 3
);
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  F;
  logic [PW-1:0] P;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  U;
  logic          norm_err;

  // Producer/consumer side: drives operands and takes results.
  modport master (
    output in_valid, F, P, out_ready,
    input  in_ready, out_valid, U, norm_err
  );

  modport slave (
    input  in_valid, F, P, out_ready,
    output in_ready, out_valid, U, norm_err
  );
endinterface
`default_nettype wire

// File: rtl/float_8bit_unpack.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : float_8bit_unpack                                               |
// | Purpose  : sequential denormalizer, U = F >> (W-1-P), one bit per clock.   |
// |            Define FLOAT_UNPACK_ROUND_EN for round-to-nearest (ties up).    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module float_8bit_unpack #(
  parameter int W  = 8,
  parameter int PW = 3
) (
  input  logic                clk,
  input  logic                rst,
  float_8bit_unpack_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  sh_q, sh_d;
  logic [W-1:0]  u_q, u_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic          out_valid_q, out_valid_d;
  logic          norm_err_q, norm_err_d;

  logic [W-1:0]  sh_next;
  logic [W-1:0]  final_val;
  logic [PW-1:0] acc_cnt;

  assign sh_next = sh_q >> 1;
  assign acc_cnt = PW'(W - 1) - bus.P;

`ifdef FLOAT_UNPACK_ROUND_EN
  // Guard is the bit leaving on the final shift; cnt>=1 keeps the sum within W bits.
  assign final_val = sh_next + {{(W-1){1'b0}}, sh_q[0]};
`else
  assign final_val = sh_next;
`endif

  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    u_d         = u_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    norm_err_d  = norm_err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          sh_d       = bus.F;
          cnt_d      = acc_cnt;
          norm_err_d = ~bus.F[W-1] && (bus.F != '0);
          if (acc_cnt == '0) begin
            u_d         = bus.F;
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end else begin
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        sh_d  = sh_next;
        cnt_d = cnt_q - PW'(1);
        if (cnt_q == PW'(1)) begin
          u_d         = final_val;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sh_q        <= '0;
      u_q         <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      norm_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      u_q         <= u_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      norm_err_q  <= norm_err_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.U         = u_q;
  assign bus.norm_err  = norm_err_q;

endmodule
`default_nettype wire

// File: tb/tb_float_8bit_unpack.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_float_8bit_unpack                                            |
// | Purpose  : directed + random self-checking bench against a value model     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_float_8bit_unpack;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  float_8bit_unpack_if #(.W(8), .PW(3)) bus ();

  float_8bit_unpack #(.W(8), .PW(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: integer value of F scaled by 2**(P-7), truncated or rounded half-up.
  function automatic int model_u(input int f, input int p);
    int c;
    c = 7 - p;
    if (c == 0) return f;
`ifdef FLOAT_UNPACK_ROUND_EN
    return (f + (1 << (c - 1))) / (1 << c);
`else
    return f / (1 << c);
`endif
  endfunction

  function automatic int model_err(input int f);
    return ((f < 128) && (f != 0)) ? 1 : 0;
  endfunction

  // One full transaction with a stalled consumer for 'stall' cycles.
  task automatic run_op(input string tag, input int f, input int p, input int exp_u,
                        input int stall, input bit poke_in);
    int cyc;
    int u_seen;
    check({tag, ".in_ready_idle"}, int'(bus.in_ready), 1);
    bus.F        = f[7:0];
    bus.P        = p[2:0];
    bus.in_valid = 1'b1;
    tick();
    cyc = 1;
    bus.in_valid = 1'b0;
    check({tag, ".in_ready_busy"}, int'(bus.in_ready), 0);
    while (!bus.out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    check({tag, ".latency"}, cyc, 8 - p);
    check({tag, ".U"}, int'(bus.U), exp_u);
    check({tag, ".norm_err"}, int'(bus.norm_err), model_err(f));
    u_seen = int'(bus.U);
    if (poke_in) begin
      bus.F        = 8'h11;
      bus.P        = 3'd7;
      bus.in_valid = 1'b1;
    end
    for (int i = 0; i < stall; i++) begin
      tick();
      check({tag, ".hold_valid"}, int'(bus.out_valid), 1);
      check({tag, ".hold_U"}, int'(bus.U), u_seen);
      check({tag, ".hold_in_ready"}, int'(bus.in_ready), 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, ".valid_fall"}, int'(bus.out_valid), 0);
    check({tag, ".in_ready_back"}, int'(bus.in_ready), 1);
  endtask

  initial begin
    int f, p;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.F         = '0;
    bus.P         = '0;
    rst           = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("reset.in_ready", int'(bus.in_ready), 1);
    check("reset.out_valid", int'(bus.out_valid), 0);
    check("reset.U", int'(bus.U), 0);
    check("reset.norm_err", int'(bus.norm_err), 0);

    run_op("t1", 8'hB4, 7, 8'hB4, 0, 1'b0);
    run_op("t2", 8'hA0, 5, 8'h28, 1, 1'b0);
    run_op("t3a", 8'h80, 0, 8'h01, 0, 1'b0);
    run_op("t3b", 8'h00, 0, 8'h00, 0, 1'b0);
    run_op("t4", 8'hF0, 6, 8'h78, 5, 1'b1);
    tick();
    check("t4.not_taken", int'(bus.in_ready), 1);
    check("t4.no_output", int'(bus.out_valid), 0);

    // Reset in the third SHIFT cycle discards the operation.
    bus.F        = 8'h80;
    bus.P        = 3'd0;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5.out_valid", int'(bus.out_valid), 0);
    check("t5.U", int'(bus.U), 0);
    check("t5.in_ready", int'(bus.in_ready), 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t5.no_output", int'(bus.out_valid), 0);
    end

`ifdef FLOAT_UNPACK_ROUND_EN
    run_op("t6a", 8'hC1, 6, 8'h61, 0, 1'b0);
`else
    run_op("t6a", 8'hC1, 6, 8'h60, 0, 1'b0);
`endif
    run_op("t6b", 8'h40, 3, 8'h04, 0, 1'b0);
    check("t6b.err_after_release", int'(bus.norm_err), 1);

    for (int n = 0; n < 40; n++) begin
      f = int'($urandom_range(0, 255));
      p = int'($urandom_range(0, 7));
      run_op("rand", f, p, model_u(f, p), int'($urandom_range(0, 2)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
